dec_pipe: RTL and testbench
===========================

DEC_PIPE -- requirements
Module: dec_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 6, meaning decoder code width (range 2..8).
REQ-002 SHALL have parameter STAGES, default 2, meaning pipeline register stages (range 1..4).
REQ-003 SHALL have parameter MASK_ZERO, default 0; when 1, code 0 decodes to all-zero (MIPS $0 write suppression).
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports below.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous pipeline clear.
REQ-008 in_valid  input  1  input transfer request.
REQ-009 in_ready  output  1  input accept.
REQ-010 in_code  input  IN_W  code to decode.
REQ-011 in_en  input  1  decode enable; 0 forces all-zero result.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_onehot  output  2**IN_W  one-hot decoded result.
REQ-015 out_code  output  IN_W  code carried alongside result.
REQ-016 out_zero  output  1  high when out_onehot is all-zero.

Function
REQ-017 Transfer SHALL occur on a rising edge with valid and ready both high; input side: in_valid&&in_ready, output side: out_valid&&out_ready.
REQ-018 Decode SHALL be: out_onehot[k]=1 iff k==code and en==1 and not (MASK_ZERO==1 and code==0); all other bits 0.
REQ-019 Decode SHALL be computed combinationally before stage 1; stages 2..STAGES only carry data.
REQ-020 Each stage k SHALL hold valid_k plus {onehot, code, zero}; stage k loads when !valid_k or stage k+1 (or out_ready for last stage) accepts.
REQ-021 in_ready SHALL equal !valid_1 || stage 1 advancing; no combinational path from in_valid to in_ready.
REQ-022 Latency SHALL be exactly STAGES cycles from input transfer to out_valid without back-pressure; throughput one transfer per cycle.
REQ-023 While out_valid && !out_ready, out_onehot, out_code, out_zero SHALL be held stable.
REQ-024 Order SHALL be preserved; no item dropped or duplicated except by flush or reset.
REQ-025 flush SHALL clear all valid_k on the next edge and take priority over a simultaneous input transfer (that input is discarded); data registers may retain values.
REQ-026 Bubbles SHALL collapse: an empty stage accepts even when downstream is stalled.
REQ-027 Pipeline SHALL hold at most STAGES items; when full and out_ready low, in_ready SHALL be 0.

Reset
REQ-028 rst_n low SHALL asynchronously clear all valid_k, out_onehot, out_code to 0 and set out_zero to 1.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight items; first input transfer allowed on first edge after rst_n release.

Structure
REQ-030 Parameter defaults and the STAGES range limits SHALL live in the shared processor package.
REQ-031 Combinational decode SHALL be one sub-module, dec_onehot (IN_W-to-2**IN_W, with en and mask_zero inputs); stage registers in dec_pipe.

Verification
REQ-032 IN_W=6, STAGES=2: code 37, en=1, out_ready=1 -> two cycles later out_valid=1, out_onehot bit 37 only, out_code=37, out_zero=0.
REQ-033 Back-pressure: out_ready=0, codes 5,6,7 offered back-to-back -> 5 and 6 accepted, in_ready=0; release -> outputs 5,6,7 in order, each held stable while stalled.
REQ-034 MASK_ZERO=1: code 0 -> out_onehot=0, out_zero=1; MASK_ZERO=0: code 0 -> bit 0 set; en=0 with code 12 -> all-zero, out_zero=1.
REQ-035 flush with pipeline full and in_valid=1 (code 9) -> next cycle out_valid=0, code 9 never emitted.
REQ-036 rst_n pulsed low mid-stream -> outputs immediately reset values, no stale item after release; then exhaustive sweep IN_W=3, STAGES=1, all 8 codes match reference model.

Source files
------------

// File: rtl/dec_pipe_pkg.sv
// Shared decoder-pipeline parameters: defaults and legal ranges.
// Pure constants; no logic, no latency.
package dec_pipe_pkg;

    localparam int DEC_IN_W_DEF      = 6;
    localparam int DEC_IN_W_MIN      = 2;
    localparam int DEC_IN_W_MAX      = 8;
    localparam int DEC_STAGES_DEF    = 2;
    localparam int DEC_STAGES_MIN    = 1;
    localparam int DEC_STAGES_MAX    = 4;
    localparam bit DEC_MASK_ZERO_DEF = 1'b0;

endpackage

// File: rtl/dec_onehot.sv
// Combinational IN_W to 2**IN_W one-hot decoder with enable and code-0 masking.
// Zero latency; no flow control.
module dec_onehot
    import dec_pipe_pkg::*;
#(
    parameter int IN_W = DEC_IN_W_DEF
) (
    input  logic [IN_W-1:0]      code,
    input  logic                 en,
    input  logic                 mask_zero,
    output logic [(1<<IN_W)-1:0] onehot,
    output logic                 zero
);

    always_comb begin
        onehot = '0;
        // Register $0 style suppression: code 0 yields no select when masked.
        if (en && !(mask_zero && (code == '0))) begin
            onehot[code] = 1'b1;
        end
    end

    assign zero = ~|onehot;

endmodule

// File: rtl/dec_pipe.sv
// One-hot decode followed by STAGES valid/ready register stages; latency STAGES cycles.
// Stalls hold output stable; empty stages accept under stall so bubbles collapse.
module dec_pipe
    import dec_pipe_pkg::*;
#(
    parameter int IN_W      = DEC_IN_W_DEF,
    parameter int STAGES    = DEC_STAGES_DEF,
    parameter bit MASK_ZERO = DEC_MASK_ZERO_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
    input  logic                 in_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [(1<<IN_W)-1:0] out_onehot,
    output logic [IN_W-1:0]      out_code,
    output logic                 out_zero
);

    localparam int OUT_W = 1 << IN_W;

    typedef struct packed {
        logic [OUT_W-1:0] onehot;
        logic [IN_W-1:0]  code;
        logic             zero;
    } stage_t;

    localparam stage_t RST_DAT = '{onehot: '0, code: '0, zero: 1'b1};

    logic [OUT_W-1:0]  dec_onehot_dat;
    logic              dec_zero;
    stage_t            stg_dat [STAGES];
    stage_t            src_dat [STAGES];
    logic [STAGES-1:0] stg_vld;
    logic [STAGES-1:0] src_vld;
    logic [STAGES:0]   stg_rdy;

    dec_onehot #(
        .IN_W (IN_W)
    ) u_dec (
        .code      (in_code),
        .en        (in_en),
        .mask_zero (MASK_ZERO),
        .onehot    (dec_onehot_dat),
        .zero      (dec_zero)
    );

    // Ready ripples from the output back; it depends only on stage state and out_ready.
    always_comb begin
        stg_rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stg_rdy[k] = !stg_vld[k] || stg_rdy[k+1];
        end
    end

    always_comb begin
        src_vld[0] = in_valid;
        src_dat[0] = '{onehot: dec_onehot_dat, code: in_code, zero: dec_zero};
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = stg_vld[k-1];
            src_dat[k] = stg_dat[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_dat[k] <= RST_DAT;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush) begin
                    stg_vld[k] <= 1'b0;
                end else if (stg_rdy[k]) begin
                    stg_vld[k] <= src_vld[k];
                end
                // Data only moves with a real item, so a stalled or empty stage keeps its value.
                if (!flush && stg_rdy[k] && src_vld[k]) begin
                    stg_dat[k] <= src_dat[k];
                end
            end
        end
    end

    assign in_ready   = stg_rdy[0];
    assign out_valid  = stg_vld[STAGES-1];
    assign out_onehot = stg_dat[STAGES-1].onehot;
    assign out_code   = stg_dat[STAGES-1].code;
    assign out_zero   = stg_dat[STAGES-1].zero;

endmodule

// File: tb/tb_dec_pipe.sv
// Bench for dec_pipe: default, code-0-masked and narrow single-stage instances
// checked against directed expectations and a queue-based reference model.
module tb_dec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, flush, in_valid, in_en, out_ready;
    logic [5:0] in_code;
    logic [2:0] in_code_s;

    logic        rdy0, vld0, zero0;
    logic [63:0] oh0;
    logic [5:0]  code0;
    logic        rdy1, vld1, zero1;
    logic [63:0] oh1;
    logic [5:0]  code1;
    logic        rdy2, vld2, zero2;
    logic [7:0]  oh2;
    logic [2:0]  code2;

    int n_cmp = 0;
    int n_err = 0;

    dec_pipe #(.IN_W(6), .STAGES(2), .MASK_ZERO(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .in_code(in_code), .in_en(in_en), .out_valid(vld0), .out_ready(out_ready),
        .out_onehot(oh0), .out_code(code0), .out_zero(zero0));

    dec_pipe #(.IN_W(6), .STAGES(2), .MASK_ZERO(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_code(in_code), .in_en(in_en), .out_valid(vld1), .out_ready(out_ready),
        .out_onehot(oh1), .out_code(code1), .out_zero(zero1));

    dec_pipe #(.IN_W(3), .STAGES(1), .MASK_ZERO(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
        .in_code(in_code_s), .in_en(in_en), .out_valid(vld2), .out_ready(out_ready),
        .out_onehot(oh2), .out_code(code2), .out_zero(zero2));

    typedef struct {
        logic [63:0] oh;
        logic [5:0]  code;
        logic        z;
    } item_t;

    // Decode rule from the definition: one bit at position code, unless disabled or masked.
    function automatic logic [63:0] ref_dec(int code, bit en, bit mz);
        logic [63:0] r;
        r = '0;
        if (en && !(mz && code == 0)) r[code] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_en = 1'b0; out_ready = 1'b0;
        in_code = '0; in_code_s = '0;
        tick(); tick();
        n_cmp++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %0b want 0", vld0); end
        n_cmp++; if (oh0 !== 64'd0) begin n_err++; $display("FAIL rst_onehot: got %h want 0", oh0); end
        n_cmp++; if (code0 !== 6'd0) begin n_err++; $display("FAIL rst_code: got %0d want 0", code0); end
        n_cmp++; if (zero0 !== 1'b1) begin n_err++; $display("FAIL rst_zero: got %0b want 1", zero0); end
        n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b want 1", rdy0); end
        n_cmp++; if (zero2 !== 1'b1) begin n_err++; $display("FAIL rst_zero_s: got %0b want 1", zero2); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decode_latency();
        out_ready = 1'b1; in_valid = 1'b1; in_code = 6'd37; in_en = 1'b1;
        #1;
        n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL lat_ready: got %0b want 1", rdy0); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL lat_early: got %0b want 0", vld0); end
        tick();
        n_cmp++; if (vld0 !== 1'b1) begin n_err++; $display("FAIL lat_vld: got %0b want 1", vld0); end
        n_cmp++; if (oh0 !== ref_dec(37, 1'b1, 1'b0)) begin n_err++; $display("FAIL lat_onehot: got %h want %h", oh0, ref_dec(37, 1'b1, 1'b0)); end
        n_cmp++; if (code0 !== 6'd37) begin n_err++; $display("FAIL lat_code: got %0d want 37", code0); end
        n_cmp++; if (zero0 !== 1'b0) begin n_err++; $display("FAIL lat_zero: got %0b want 0", zero0); end
        tick();
        n_cmp++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL lat_single: got %0b want 0", vld0); end
    endtask

    task automatic test_mask_en();
        out_ready = 1'b1; in_valid = 1'b1; in_code = 6'd0; in_en = 1'b1;
        tick();
        in_code = 6'd12; in_en = 1'b0;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (vld1 !== 1'b1 || oh1 !== 64'd0 || zero1 !== 1'b1) begin n_err++; $display("FAIL mask_code0: got vld %0b oh %h z %0b want 1 0 1", vld1, oh1, zero1); end
        n_cmp++; if (vld0 !== 1'b1 || oh0 !== 64'd1 || zero0 !== 1'b0) begin n_err++; $display("FAIL nomask_code0: got vld %0b oh %h z %0b want 1 1 0", vld0, oh0, zero0); end
        tick();
        n_cmp++; if (vld0 !== 1'b1 || oh0 !== 64'd0 || zero0 !== 1'b1 || code0 !== 6'd12) begin n_err++; $display("FAIL en_off: got vld %0b oh %h z %0b code %0d want 1 0 1 12", vld0, oh0, zero0, code0); end
        n_cmp++; if (oh1 !== 64'd0 || zero1 !== 1'b1) begin n_err++; $display("FAIL en_off_mask: got oh %h z %0b want 0 1", oh1, zero1); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [5:0] got[$];
        bit acc;
        out_ready = 1'b0; in_en = 1'b1; in_valid = 1'b1; in_code = 6'd5;
        #1;
        n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL bp_acc5: got %0b want 1", rdy0); end
        tick();
        in_code = 6'd6;
        #1;
        n_cmp++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL bp_acc6: got %0b want 1", rdy0); end
        tick();
        in_code = 6'd7;
        #1;
        n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL bp_full: got %0b want 0", rdy0); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (vld0 !== 1'b1 || code0 !== 6'd5 || oh0 !== ref_dec(5, 1'b1, 1'b0) || rdy0 !== 1'b0) begin
                n_err++; $display("FAIL bp_hold: got vld %0b code %0d oh %h rdy %0b want 1 5 %h 0", vld0, code0, oh0, rdy0, ref_dec(5, 1'b1, 1'b0));
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && got.size() < 3; i++) begin
            #1;
            acc = in_valid && rdy0;
            if (vld0) begin
                got.push_back(code0);
                n_cmp++; if (oh0 !== ref_dec(int'(code0), 1'b1, 1'b0)) begin n_err++; $display("FAIL bp_onehot: got %h for code %0d", oh0, code0); end
            end
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL bp_count: got %0d want 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            n_cmp++; if (got[i] !== 6'(5 + i)) begin n_err++; $display("FAIL bp_order: got %0d want %0d", got[i], 5 + i); end
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_en = 1'b1; in_valid = 1'b1; in_code = 6'd20;
        tick();
        in_code = 6'd21;
        tick();
        n_cmp++; if (rdy0 !== 1'b0 || vld0 !== 1'b1) begin n_err++; $display("FAIL fl_full: got rdy %0b vld %0b want 0 1", rdy0, vld0); end
        flush = 1'b1; in_code = 6'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL fl_clear: got %0b want 0", vld0); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL fl_leak: got vld %0b code %0d want 0", vld0, code0); end
        end
    endtask

    task automatic test_random();
        item_t q[$];
        item_t it;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_code   = 6'($urandom_range(0, 63));
            in_en     = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 59) == 0);
            #1;
            n_cmp++; if (rdy0 !== (q.size() < 2 || out_ready)) begin
                n_err++; $display("FAIL rnd_ready: got %0b want %0b (held %0d)", rdy0, (q.size() < 2 || out_ready), q.size());
            end
            if (vld0) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_spurious: got code %0d want no item", code0);
                end else if (oh0 !== q[0].oh || code0 !== q[0].code || zero0 !== q[0].z) begin
                    n_err++; $display("FAIL rnd_data: got %h/%0d/%0b want %h/%0d/%0b", oh0, code0, zero0, q[0].oh, q[0].code, q[0].z);
                end
                if (out_ready && q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && rdy0) begin
                it.oh   = ref_dec(int'(in_code), in_en, 1'b0);
                it.code = in_code;
                it.z    = (it.oh == 64'd0);
                q.push_back(it);
            end
            if (flush) q.delete();
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            if (vld0) begin
                n_cmp++; if (code0 !== q[0].code || oh0 !== q[0].oh) begin n_err++; $display("FAIL rnd_drain: got %0d want %0d", code0, q[0].code); end
                void'(q.pop_front());
            end
            tick();
        end
        n_cmp++; if (q.size() != 0 || vld0 !== 1'b0) begin n_err++; $display("FAIL rnd_empty: got %0d left vld %0b want 0 0", q.size(), vld0); end
    endtask

    task automatic test_reset_midstream();
        logic [63:0] r;
        out_ready = 1'b0; in_en = 1'b1; in_valid = 1'b1; in_code = 6'd1;
        tick();
        in_code = 6'd2;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (vld0 !== 1'b0 || oh0 !== 64'd0 || code0 !== 6'd0 || zero0 !== 1'b1) begin
            n_err++; $display("FAIL mid_rst: got vld %0b oh %h code %0d z %0b want 0 0 0 1", vld0, oh0, code0, zero0);
        end
        in_code = 6'd44; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL mid_stale: got %0b want 0", vld0); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL mid_early: got %0b want 0", vld0); end
        tick();
        n_cmp++; if (vld0 !== 1'b1 || code0 !== 6'd44) begin n_err++; $display("FAIL mid_first: got vld %0b code %0d want 1 44", vld0, code0); end
        tick(); tick();
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_code_s = 3'(c); in_en = 1'b1;
            #1;
            n_cmp++; if (rdy2 !== 1'b1) begin n_err++; $display("FAIL sweep_ready: got %0b want 1", rdy2); end
            tick();
            r = ref_dec(c, 1'b1, 1'b0);
            n_cmp++; if (vld2 !== 1'b1 || oh2 !== r[7:0] || code2 !== 3'(c) || zero2 !== 1'b0) begin
                n_err++; $display("FAIL sweep_%0d: got vld %0b oh %b code %0d z %0b want 1 %b %0d 0", c, vld2, oh2, code2, zero2, r[7:0], c);
            end
        end
        in_code_s = 3'd6; in_en = 1'b0;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (vld2 !== 1'b1 || oh2 !== 8'd0 || zero2 !== 1'b1) begin n_err++; $display("FAIL sweep_en0: got vld %0b oh %b z %0b want 1 0 1", vld2, oh2, zero2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_decode_latency();
        test_mask_en();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
